ser_word_tx: RTL

SER_WORD_TX -- requirements
Module: ser_word_tx

---
 rtl/ser_word_tx.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/ser_word_tx.sv
`default_nettype none
// ============================================================================
// Module      : ser_word_tx
// Description : Serialises an 8-bit word LSB-first on sdo, framed by the
//               active-low frame_n strobe, followed by a GAP_CYCLES idle
//               period. The done output pulses for one cycle when the frame
//               ends. Define SER_WORD_TX_PARITY_EN to append an even-parity
//               bit, making the frame 9 bits long.
// Revision    : 1.0 - initial release
// ============================================================================
module ser_word_tx #(
  parameter int GAP_CYCLES = 1            // legal range 1..15
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       sdo,
  output logic       frame_n,
  output logic       done
);

`ifdef SER_WORD_TX_PARITY_EN
  localparam int         FRAME_BITS = 9;
  localparam logic [3:0] DATA_LAST  = 4'd7;
`else
  localparam int         FRAME_BITS = 8;
`endif
  localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] sreg, sreg_nxt;
  logic [3:0] bit_cnt, bit_nxt;
  logic [3:0] gap_cnt, gap_nxt;
  logic       sdo_nxt;
  logic       frame_n_nxt;
  logic       done_nxt;
`ifdef SER_WORD_TX_PARITY_EN
  logic       par, par_nxt;
`endif

  // Ready is a pure state decode, so it never depends on tx_valid.
  assign tx_ready = (state == IDLE);

  // State and registered outputs; reset is asynchronous and aborts any frame.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sreg    <= 8'h00;
      bit_cnt <= 4'd0;
      gap_cnt <= 4'd0;
      sdo     <= 1'b0;
      frame_n <= 1'b1;
      done    <= 1'b0;
`ifdef SER_WORD_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else begin
      state   <= state_nxt;
      sreg    <= sreg_nxt;
      bit_cnt <= bit_nxt;
      gap_cnt <= gap_nxt;
      sdo     <= sdo_nxt;
      frame_n <= frame_n_nxt;
      done    <= done_nxt;
`ifdef SER_WORD_TX_PARITY_EN
      par     <= par_nxt;
`endif
    end
  end

  // Next-state and next-output decode; outputs default to the idle levels.
  always_comb begin
    state_nxt   = state;
    sreg_nxt    = sreg;
    bit_nxt     = bit_cnt;
    gap_nxt     = gap_cnt;
    sdo_nxt     = 1'b0;
    frame_n_nxt = 1'b1;
    done_nxt    = 1'b0;
`ifdef SER_WORD_TX_PARITY_EN
    par_nxt     = par;
`endif
    case (state)
      IDLE: begin
        if (tx_valid) begin
          // Accept: bit 0 goes straight onto sdo at this edge.
          state_nxt   = SHIFT;
          sreg_nxt    = tx_data;
          bit_nxt     = 4'd0;
          gap_nxt     = 4'd0;
          sdo_nxt     = tx_data[0];
          frame_n_nxt = 1'b0;
`ifdef SER_WORD_TX_PARITY_EN
          par_nxt     = ^tx_data;
`endif
        end
      end

      SHIFT: begin
        if (bit_cnt >= LAST_BIT) begin
          // Last frame bit has been on the line for one cycle: close frame.
          // bit_cnt is left saturated at LAST_BIT.
          state_nxt = GAP;
          gap_nxt   = 4'd0;
          done_nxt  = 1'b1;
        end else begin
          // Rotate rather than shift so the word stays intact in the register;
          // the next bit to send is always in position 1 before the rotate.
          bit_nxt     = bit_cnt + 4'd1;
          frame_n_nxt = 1'b0;
          sreg_nxt    = {sreg[0], sreg[7:1]};
          sdo_nxt     = sreg[1];
`ifdef SER_WORD_TX_PARITY_EN
          if (bit_cnt == DATA_LAST) begin
            sdo_nxt = par;
          end
`endif
        end
      end

      GAP: begin
        if (gap_cnt >= GAP_LAST) begin
          state_nxt = IDLE;
        end else begin
          gap_nxt = gap_cnt + 4'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire
